// File: rtl/thermo_code_gen_pkg.sv
// Shared encodings for the thermometer-code generator.
// Mode and FSM state types used by the top and the bench.
package thermo_code_gen_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_ADV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/thermo_code_gen_if.sv
// Command and code-stream bundle for the thermometer-code generator.
// master drives commands and code_ready, slave is the generator.
interface thermo_code_gen_if #(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8,
    parameter int HOLD_W    = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_mode;
    logic [BITS_DECO-1:0] cmd_bin;
    logic                 cmd_bubble;
    logic [HOLD_W-1:0]    cmd_hold;
    logic [NUM_FF-1:0]    code_out;
    logic [BITS_DECO-1:0] code_bin;
    logic                 code_valid;
    logic                 code_ready;

    modport master (
        output cmd_valid, cmd_mode, cmd_bin, cmd_bubble, cmd_hold, code_ready,
        input  cmd_ready, code_out, code_bin, code_valid
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_bin, cmd_bubble, cmd_hold, code_ready,
        output cmd_ready, code_out, code_bin, code_valid
    );
endinterface

// File: rtl/thermo_code_gen_expand.sv
// Combinational bin -> thermometer word, ones from bit cur upward.
// Optional bubble clears bit cur+1 when it exists in the word.
module thermo_code_gen_expand #(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8
) (
    input  logic [BITS_DECO-1:0] cur,
    input  logic                 bubble,
    output logic [NUM_FF-1:0]    word
);
    localparam int W = BITS_DECO + 1;

    logic [W-1:0] cw;
    logic [W-1:0] cw1;

    assign cw  = {1'b0, cur};
    assign cw1 = cw + W'(1);

    for (genvar k = 0; k < NUM_FF; k++) begin : g_bit
        assign word[k] = (W'(k) >= cw) && !(bubble && (W'(k) == cw1));
    end
endmodule

// File: rtl/thermo_code_gen.sv
// Thermometer-code generator: single pattern or sweep to NUM_FF,
// with per-pattern repeat, bubble injection and abort.
module thermo_code_gen
    import thermo_code_gen_pkg::*;
#(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8,
    parameter int HOLD_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    thermo_code_gen_if.slave    bus,
    input  logic                abort,
    output logic                busy,
    output logic                done
);
    localparam logic [BITS_DECO-1:0] LAST_BIN = BITS_DECO'(NUM_FF);

    state_t               state_q;
    state_t               state_n;
    logic [BITS_DECO-1:0] cur_q;
    logic [BITS_DECO-1:0] cur_n;
    logic [HOLD_W-1:0]    rep_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 mode_q;
    logic                 bubble_q;
    logic                 bubble_n;
    logic [NUM_FF-1:0]    word_n;
    logic [NUM_FF-1:0]    code_out_q;
    logic [BITS_DECO-1:0] code_bin_q;
    logic                 accept;
    logic                 beat;
    logic                 last_rep;

    assign accept   = (state_q == S_IDLE) && bus.cmd_valid;
    assign beat     = (state_q == S_EMIT) && bus.code_ready;
    assign last_rep = (rep_q == hold_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) state_n = S_EMIT;
            S_EMIT: begin
                if (abort)                 state_n = S_FIN;
                else if (beat && last_rep) state_n = S_ADV;
            end
            S_ADV: begin
                if (abort || mode_q == MODE_SINGLE || cur_q == LAST_BIN)
                    state_n = S_FIN;
                else
                    state_n = S_EMIT;
            end
            S_FIN: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.code_valid = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = ~rst;
                busy          = 1'b0;
            end
            S_EMIT: bus.code_valid = 1'b1;
            S_ADV:  ;
            S_FIN:  done = 1'b1;
        endcase
    end

    // next pattern values, so the word register loads as EMIT is entered
    always_comb begin
        cur_n    = cur_q;
        bubble_n = bubble_q;
        if (accept) begin
            cur_n    = (bus.cmd_bin > LAST_BIN) ? LAST_BIN : bus.cmd_bin;
            bubble_n = bus.cmd_bubble;
        end else if (state_q == S_ADV && state_n == S_EMIT) begin
            cur_n = cur_q + BITS_DECO'(1);
        end
    end

    thermo_code_gen_expand #(
        .NUM_FF    (NUM_FF),
        .BITS_DECO (BITS_DECO)
    ) u_expand (
        .cur    (cur_n),
        .bubble (bubble_n),
        .word   (word_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q      <= '0;
            rep_q      <= '0;
            hold_q     <= '0;
            mode_q     <= MODE_SINGLE;
            bubble_q   <= 1'b0;
            code_out_q <= '0;
            code_bin_q <= '0;
        end else begin
            cur_q    <= cur_n;
            bubble_q <= bubble_n;
            if (accept) begin
                mode_q <= bus.cmd_mode;
                hold_q <= bus.cmd_hold;
                rep_q  <= '0;
            end else if (beat && !last_rep) begin
                rep_q <= rep_q + HOLD_W'(1);
            end else if (state_q == S_ADV) begin
                rep_q <= '0;
            end
            if (state_n == S_EMIT && state_q != S_EMIT) begin
                code_out_q <= word_n;
                code_bin_q <= cur_n;
            end
        end
    end

    assign bus.code_out = code_out_q;
    assign bus.code_bin = code_bin_q;
endmodule
